conv_window: RTL



---
 rtl/conv_window.sv | 111 +++++++++++
 1 files changed

// File: rtl/conv_window.sv
// Sliding-window former: collects KERNEL_LEN consecutive feature vectors of a frame
// and presents them as one wide window to the conv1d MAC array.
module conv_window #(
   parameter  int BW         = 8,
   parameter  int VECTOR_LEN = 13,
   parameter  int KERNEL_LEN = 3,
   localparam int VECTOR_BW  = VECTOR_LEN * BW,
   localparam int WINDOW_BW  = KERNEL_LEN * VECTOR_BW,
   localparam int CNT_BW     = $clog2(KERNEL_LEN) + 1
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic signed [VECTOR_BW-1:0] data_i,
   input  logic                        valid_i,
   input  logic                        last_i,
   output logic                        ready_o,
   output logic signed [WINDOW_BW-1:0] data_o,
   output logic                        valid_o,
   output logic                        last_o,
   input  logic                        ready_i
);

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [CNT_BW-1:0] CNT_FULL = CNT_BW'(KERNEL_LEN - 1);
   localparam logic [CNT_BW-1:0] CNT_MAX  = CNT_BW'(KERNEL_LEN);

   state_t                 state_q;
   logic [CNT_BW-1:0]      cnt_q;
   logic [CNT_BW-1:0]      cnt_d;
   logic [WINDOW_BW-1:0]   win_q;
   logic [WINDOW_BW-1:0]   win_d;
   logic [WINDOW_BW-1:0]   data_q;
   logic                   valid_q;
   logic                   last_q;
   logic                   acc;
   logic                   xfer;

   // The single output register is the only buffer, so input stalls whenever it is held.
   assign ready_o = !valid_q | ready_i;
   assign acc     = valid_i & ready_o;
   assign xfer    = valid_q & ready_i;

   // Newest vector enters the MSB slot; the oldest falls out of the LSB slot.
   assign win_d = {data_i, win_q[WINDOW_BW-1:VECTOR_BW]};
   assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : CNT_BW'(cnt_q + CNT_BW'(1));

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign last_o  = last_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= FILL;
         cnt_q   <= '0;
         win_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         if (acc) begin
            win_q <= win_d;
         end
         case (state_q)
            FILL: begin
               if (acc) begin
                  if (last_i) begin
                     cnt_q   <= '0;
                     state_q <= FILL;
                  end else begin
                     cnt_q   <= cnt_d;
                     state_q <= (cnt_d >= CNT_FULL) ? RUN : FILL;
                  end
               end
               if (xfer) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
               end
            end
            RUN: begin
               if (acc) begin
                  // Emit replaces any window leaving this cycle, giving one window per cycle.
                  valid_q <= 1'b1;
                  data_q  <= win_d;
                  last_q  <= last_i;
                  if (last_i) begin
                     cnt_q   <= '0;
                     state_q <= FILL;
                  end else begin
                     cnt_q   <= cnt_d;
                     state_q <= RUN;
                  end
               end else if (xfer) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= FILL;
               cnt_q   <= '0;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
